// File: rtl/serial_in_parallel_out_pkg.sv
// Shared constants for the 4-stage serial-in, parallel-out shift register.
package serial_in_parallel_out_pkg;

  // Number of flop stages in the chain, one parallel output per stage.
  localparam int SIPO_DEPTH = 4;

  // Value loaded into every stage on reset and at power-up.
  localparam logic RESET_VAL = 1'b0;

endpackage

// File: rtl/serial_in_parallel_out_shift_stage.sv
// Single D flop with synchronous active-high reset.
// One link of the serial-in, parallel-out chain.
module shift_stage
  import serial_in_parallel_out_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // The declaration initial value gives a known 0 at power-up, even before any reset edge.
  logic stage = RESET_VAL;

  // Reset wins over the incoming bit; otherwise capture the upstream value every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= RESET_VAL;
    end else begin
      stage <= d;
    end
  end

  assign q = stage;

endmodule

// File: rtl/serial_in_parallel_out.sv
// 4-stage serial-in, parallel-out shift register.
// A new serial bit enters on every rising edge; all stages are visible at once.
// Outputs come straight from the flops, so there is no combinational path from din.
module serial_in_parallel_out
  import serial_in_parallel_out_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd
);

  // chain[0] is the serial input; chain[i+1] is the output of stage i.
  logic [SIPO_DEPTH:0] chain;

  assign chain[0] = din;

  // Stage 0 takes din, and every later stage takes the previous stage's output.
  for (genvar i = 0; i < SIPO_DEPTH; i++) begin : g_stage
    shift_stage u_stage (
      .clk (clk),
      .rst (rst),
      .d   (chain[i]),
      .q   (chain[i+1])
    );
  end

  assign qa = chain[1];
  assign qb = chain[2];
  assign qc = chain[3];
  assign qd = chain[4];

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Scoreboard testbench for serial_in_parallel_out.
// The stimulus process drives rst/din on the falling edge and queues the
// hand-computed {qd,qc,qb,qa} expected after the next rising edge. The monitor
// process pops and compares shortly after every rising edge.
module tb_serial_in_parallel_out;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic qa, qb, qc, qd;

  int checks = 0;
  int failures = 0;

  logic [3:0] expq[$];

  serial_in_parallel_out dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .qa  (qa),
    .qb  (qb),
    .qc  (qc),
    .qd  (qd)
  );

  // 20 ns clock period; the first rising edge is at 10 ns.
  always #10 clk = ~clk;

  // Each vector is {rst, din, expected {qd,qc,qb,qa} after the edge}.
  localparam int NVEC = 40;
  logic [5:0] vecs [NVEC] = '{
    // Power-up without a reset edge: shift directly from the all-zero state.
    {1'b0, 1'b1, 4'b0001},
    {1'b0, 1'b0, 4'b0010},
    // Reset held for two edges with din=1.
    {1'b1, 1'b1, 4'b0000},
    {1'b1, 1'b1, 4'b0000},
    // Single-pulse propagation.
    {1'b0, 1'b1, 4'b0001},
    {1'b0, 1'b0, 4'b0010},
    {1'b0, 1'b0, 4'b0100},
    {1'b0, 1'b0, 4'b1000},
    {1'b0, 1'b0, 4'b0000},
    // Pattern fill 1,0,1,1.
    {1'b0, 1'b1, 4'b0001},
    {1'b0, 1'b0, 4'b0010},
    {1'b0, 1'b1, 4'b0101},
    {1'b0, 1'b1, 4'b1011},
    // Fill with ones.
    {1'b0, 1'b1, 4'b0111},
    {1'b0, 1'b1, 4'b1111},
    // Mid-stream reset, then resume with din=1.
    {1'b1, 1'b1, 4'b0000},
    {1'b0, 1'b1, 4'b0001},
    // Continuous stream, din constant for 2-3 edges at a time.
    {1'b0, 1'b1, 4'b0011},
    {1'b0, 1'b1, 4'b0111},
    {1'b0, 1'b0, 4'b1110},
    {1'b0, 1'b0, 4'b1100},
    {1'b0, 1'b0, 4'b1000},
    {1'b0, 1'b1, 4'b0001},
    {1'b0, 1'b1, 4'b0011},
    {1'b0, 1'b0, 4'b0110},
    {1'b0, 1'b0, 4'b1100},
    {1'b0, 1'b1, 4'b1001},
    {1'b0, 1'b1, 4'b0011},
    {1'b0, 1'b1, 4'b0111},
    // din held at 1: register saturates and stays put.
    {1'b0, 1'b1, 4'b1111},
    {1'b0, 1'b1, 4'b1111},
    // din held at 0: register drains within four edges.
    {1'b0, 1'b0, 4'b1110},
    {1'b0, 1'b0, 4'b1100},
    {1'b0, 1'b0, 4'b1000},
    {1'b0, 1'b0, 4'b0000},
    {1'b0, 1'b0, 4'b0000},
    // Alternating bits to separate neighbouring stages.
    {1'b0, 1'b1, 4'b0001},
    {1'b0, 1'b0, 4'b0010},
    {1'b0, 1'b1, 4'b0101},
    {1'b0, 1'b0, 4'b1010}
  };

  // Apply one vector on the falling edge and queue its expected result.
  task automatic applyStimulus(input logic r, input logic d, input logic [3:0] e);
    @(negedge clk);
    rst = r;
    din = d;
    expq.push_back(e);
  endtask

  // Compare one observed parallel word against its expected value.
  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected word is retired just after every rising edge that has one pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        checkOutput("shift", {qd, qc, qb, qa}, expq.pop_front());
      end
    end
  end

  // Stimulus: rst is low from time zero, so the first edge already shifts.
  initial begin
    rst = 1'b0;
    din = 1'b0;
    #1;
    checkOutput("powerup", {qd, qc, qb, qa}, 4'b0000);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i][5], vecs[i][4], vecs[i][3:0]);
    end

    // A short rst pulse between edges must not clear anything.
    @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    expq.push_back(4'b0101);
    #3 rst = 1'b1;
    #3 rst = 1'b0;

    @(negedge clk);
    din = 1'b1;
    expq.push_back(4'b1011);

    // Let the monitor drain the queue, bounded by a cycle budget.
    for (int w = 0; w < 10 && expq.size() > 0; w++) begin
      @(negedge clk);
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d pending expected 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
